// File: rtl/door_pkg.sv
//------------------------------------------------------------------------------
// Module  : door_pkg
// Brief   : Shared state encoding, parameter defaults and helpers for the
//           door access controller.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package door_pkg;

    localparam int c_PIN_DIGITS_DFLT     = 4;
    localparam int c_MOTOR_CYCLES_DFLT   = 50;
    localparam int c_RELOCK_CYCLES_DFLT  = 1000;
    localparam int c_MAX_TRIES_DFLT      = 3;
    localparam int c_LOCKOUT_CYCLES_DFLT = 5000;

    localparam logic [3:0] c_MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        ST_LOCKED    = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_UNLOCKING = 3'd2,
        ST_UNLOCKED  = 3'd3,
        ST_LOCKING   = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/door_access_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : door_access_ctrl_if
// Brief   : Keypad, configuration, lock button and motor/status signal bundle.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface door_access_ctrl_if #(
    parameter int PIN_DIGITS = door_pkg::c_PIN_DIGITS_DFLT
);
    logic                    key_valid;
    logic [3:0]              key_digit;
    logic [4*PIN_DIGITS-1:0] pin_cfg;
    logic                    lock_req;
    logic                    m_cw;
    logic                    m_acw;
    logic                    unlocked;
    logic                    alarm;

    modport master (
        output key_valid, key_digit, pin_cfg, lock_req,
        input  m_cw, m_acw, unlocked, alarm
    );

    modport slave (
        input  key_valid, key_digit, pin_cfg, lock_req,
        output m_cw, m_acw, unlocked, alarm
    );
endinterface

`default_nettype wire

// File: rtl/door_access_ctrl_cycle_timer.sv
//------------------------------------------------------------------------------
// Module  : cycle_timer
// Brief   : Loadable down-counter; o_expire pulses on the last of i_load cycles.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             CLK,
    input  wire logic             RST_N,
    input  wire logic             i_start,
    input  wire logic [WIDTH-1:0] i_load,
    output logic                  o_expire
);
    logic [WIDTH-1:0] r_count;
    logic             r_active;

    // A restart wins over an expiry in the same cycle so back-to-back phases chain.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_count  <= i_load;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_count <= r_count - WIDTH'(1);
            if (r_count == WIDTH'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_expire = r_active && (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/door_access_ctrl.sv
//------------------------------------------------------------------------------
// Module  : door_access_ctrl
// Brief   : Keypad door lock FSM with motor pulses, auto-relock and lockout.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module door_access_ctrl
    import door_pkg::*;
#(
    parameter int PIN_DIGITS     = c_PIN_DIGITS_DFLT,
    parameter int MOTOR_CYCLES   = c_MOTOR_CYCLES_DFLT,
    parameter int RELOCK_CYCLES  = c_RELOCK_CYCLES_DFLT,
    parameter int MAX_TRIES      = c_MAX_TRIES_DFLT,
    parameter int LOCKOUT_CYCLES = c_LOCKOUT_CYCLES_DFLT
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    door_access_ctrl_if.slave bus
);
    localparam int c_TMR_W  = $clog2(max3(MOTOR_CYCLES, RELOCK_CYCLES, LOCKOUT_CYCLES)) + 1;
    localparam int c_IDX_W  = $clog2(PIN_DIGITS) + 1;
    localparam int c_FAIL_W = $clog2(MAX_TRIES) + 1;

    state_t              r_state, w_state_nxt;
    logic [c_IDX_W-1:0]  r_idx, w_idx_nxt;
    logic                r_mismatch, w_mismatch_nxt;
    logic [c_FAIL_W-1:0] r_fail, w_fail_nxt, w_fail_inc;
    logic                r_m_cw, r_m_acw, r_unlocked, r_alarm;
    logic                w_tmr_start, w_tmr_expire;
    logic [c_TMR_W-1:0]  w_tmr_load;
    logic [3:0]          w_exp_digit;
    logic                w_digit_ok, w_abort, w_mis_acc, w_last;

    cycle_timer #(.WIDTH(c_TMR_W)) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_start  (w_tmr_start),
        .i_load   (w_tmr_load),
        .o_expire (w_tmr_expire)
    );

    // Index stays 0 in LOCKED, so the same selector serves the first digit.
    always_comb begin
        w_exp_digit = '0;
        for (int i = 0; i < PIN_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_exp_digit = bus.pin_cfg[4*(PIN_DIGITS-1-i) +: 4];
            end
        end
    end

    assign w_digit_ok = bus.key_valid && (bus.key_digit <= c_MAX_DIGIT);
    assign w_abort    = bus.key_valid && (bus.key_digit >  c_MAX_DIGIT);
    assign w_mis_acc  = r_mismatch || (bus.key_digit != w_exp_digit);
    assign w_last     = (r_idx == c_IDX_W'(PIN_DIGITS - 1));
    assign w_fail_inc = r_fail + c_FAIL_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_mismatch_nxt = r_mismatch;
        w_fail_nxt     = r_fail;
        w_tmr_start    = 1'b0;
        w_tmr_load     = c_TMR_W'(MOTOR_CYCLES);
        case (r_state)
            ST_LOCKED, ST_ENTRY: begin
                if (w_digit_ok) begin
                    if (w_last) begin
                        w_idx_nxt      = '0;
                        w_mismatch_nxt = 1'b0;
                        if (!w_mis_acc) begin
                            w_state_nxt = ST_UNLOCKING;
                            w_fail_nxt  = '0;
                            w_tmr_start = 1'b1;
                        end else if (w_fail_inc == c_FAIL_W'(MAX_TRIES)) begin
                            w_state_nxt = ST_LOCKOUT;
                            w_fail_nxt  = w_fail_inc;
                            w_tmr_start = 1'b1;
                            w_tmr_load  = c_TMR_W'(LOCKOUT_CYCLES);
                        end else begin
                            w_state_nxt = ST_LOCKED;
                            w_fail_nxt  = w_fail_inc;
                        end
                    end else begin
                        w_state_nxt    = ST_ENTRY;
                        w_idx_nxt      = r_idx + c_IDX_W'(1);
                        w_mismatch_nxt = w_mis_acc;
                    end
                end else if (w_abort && (r_state == ST_ENTRY)) begin
                    w_state_nxt    = ST_LOCKED;
                    w_idx_nxt      = '0;
                    w_mismatch_nxt = 1'b0;
                end
            end
            ST_UNLOCKING: begin
                if (w_tmr_expire) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = c_TMR_W'(RELOCK_CYCLES);
                end
            end
            ST_UNLOCKED: begin
                if (bus.lock_req || w_tmr_expire) begin
                    w_state_nxt = ST_LOCKING;
                    w_tmr_start = 1'b1;
                end
            end
            ST_LOCKING: begin
                if (w_tmr_expire) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (w_tmr_expire) begin
                    w_state_nxt = ST_LOCKED;
                    w_fail_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_LOCKED;
                w_idx_nxt      = '0;
                w_mismatch_nxt = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_LOCKED;
            r_idx      <= '0;
            r_mismatch <= 1'b0;
            r_fail     <= '0;
            r_m_cw     <= 1'b0;
            r_m_acw    <= 1'b0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_fail     <= w_fail_nxt;
            r_m_cw     <= (w_state_nxt == ST_LOCKING);
            r_m_acw    <= (w_state_nxt == ST_UNLOCKING);
            r_unlocked <= (w_state_nxt == ST_UNLOCKED);
            r_alarm    <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign bus.m_cw     = r_m_cw;
    assign bus.m_acw    = r_m_acw;
    assign bus.unlocked = r_unlocked;
    assign bus.alarm    = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_door_access_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_door_access_ctrl
// Brief   : Directed self-checking bench with a code/deadline reference model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_door_access_ctrl;
    localparam int          PIN_DIGITS = 4;
    localparam int          MOTOR      = 4;
    localparam int          RELOCK     = 20;
    localparam int          MAX_TRIES  = 3;
    localparam int          LOCKOUT    = 10;
    localparam logic [15:0] PIN        = 16'h1234;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    door_access_ctrl_if #(.PIN_DIGITS(PIN_DIGITS)) bus ();

    door_access_ctrl #(
        .PIN_DIGITS     (PIN_DIGITS),
        .MOTOR_CYCLES   (MOTOR),
        .RELOCK_CYCLES  (RELOCK),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: digits collected in a queue, whole code compared at the end;
    // timed phases end at an absolute cycle number.
    typedef enum int {M_IDLE, M_OPENING, M_OPEN, M_CLOSING, M_ALARM} mode_t;
    mode_t  m_mode = M_IDLE;
    int     m_q[$];
    int     m_fails = 0;
    longint cyc = 0;
    longint m_end = 0;
    bit     m_ok;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mode  = M_IDLE;
            m_q.delete();
            m_fails = 0;
        end else begin
            cyc++;
            case (m_mode)
                M_IDLE: if (bus.key_valid) begin
                    if (bus.key_digit <= 4'd9) begin
                        m_q.push_back(int'(bus.key_digit));
                        if (m_q.size() == PIN_DIGITS) begin
                            m_ok = 1'b1;
                            for (int i = 0; i < PIN_DIGITS; i++)
                                if (m_q[i] != int'((PIN >> (4*(PIN_DIGITS-1-i))) & 16'hF))
                                    m_ok = 1'b0;
                            m_q.delete();
                            if (m_ok) begin
                                m_mode  = M_OPENING;
                                m_end   = cyc + MOTOR;
                                m_fails = 0;
                            end else begin
                                m_fails++;
                                if (m_fails >= MAX_TRIES) begin
                                    m_mode = M_ALARM;
                                    m_end  = cyc + LOCKOUT;
                                end
                            end
                        end
                    end else begin
                        m_q.delete();
                    end
                end
                M_OPENING: if (cyc == m_end) begin
                    m_mode = M_OPEN;
                    m_end  = cyc + RELOCK;
                end
                M_OPEN: if (bus.lock_req || cyc == m_end) begin
                    m_mode = M_CLOSING;
                    m_end  = cyc + MOTOR;
                end
                M_CLOSING: if (cyc == m_end) m_mode = M_IDLE;
                M_ALARM: if (cyc == m_end) begin
                    m_mode  = M_IDLE;
                    m_fails = 0;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("m_acw vs model",    int'(bus.m_acw),    int'(m_mode == M_OPENING));
        chk("m_cw vs model",     int'(bus.m_cw),     int'(m_mode == M_CLOSING));
        chk("unlocked vs model", int'(bus.unlocked), int'(m_mode == M_OPEN));
        chk("alarm vs model",    int'(bus.alarm),    int'(m_mode == M_ALARM));
        chk("motor exclusive",   int'(bus.m_cw & bus.m_acw), 0);
    endtask

    always @(posedge CLK) begin
        #1;
        if (RST_N) compare_model();
    end

    always @(negedge RST_N) begin
        #1;
        compare_model();
    end

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.m_acw;
            1:       return bus.m_cw;
            2:       return bus.unlocked;
            default: return bus.alarm;
        endcase
    endfunction

    // Counts consecutive negedges on which the selected output is high.
    task automatic count_high(input int w, output int n);
        n = 0;
        while (sig(w) && n < 200) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge CLK);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        @(negedge CLK);
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    task automatic enter(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(code[15-4*i -: 4]);
    endtask

    task automatic chk_idle(input string name);
        chk({name, " m_acw"},    int'(bus.m_acw),    0);
        chk({name, " m_cw"},     int'(bus.m_cw),     0);
        chk({name, " unlocked"}, int'(bus.unlocked), 0);
        chk({name, " alarm"},    int'(bus.alarm),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int n;

    initial begin
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.lock_req  = 1'b0;
        bus.pin_cfg   = PIN;
        repeat (2) @(negedge CLK);
        chk_idle("reset");
        RST_N = 1'b1;

        // Abort code and lock button are ignored while locked.
        @(negedge CLK);
        bus.lock_req = 1'b1;
        press(4'hB);
        bus.lock_req = 1'b0;
        @(negedge CLK);
        chk_idle("locked ignore");

        // Correct code, motor pulse, auto-relock.
        enter(16'h1234);
        chk("unlock acw start", int'(bus.m_acw), 1);
        count_high(0, n);  chk("acw length", n, 4);
        chk("unlocked after acw", int'(bus.unlocked), 1);
        count_high(2, n);  chk("relock delay", n, 20);
        count_high(1, n);  chk("cw length", n, 4);
        chk_idle("after relock");

        // Three wrong codes -> lockout; keys during lockout are ignored.
        enter(16'h1235);
        enter(16'h1235);
        chk("no alarm after 2 fails", int'(bus.alarm), 0);
        enter(16'h1235);
        chk("alarm start", int'(bus.alarm), 1);
        enter(16'h1234);  // 8 more lockout cycles; cycle 9 is now showing
        chk("alarm held", int'(bus.alarm), 1);
        chk("keys ignored in lockout", int'(bus.m_acw), 0);
        count_high(3, n);  chk("alarm remaining", n, 2);
        chk_idle("after lockout");
        enter(16'h1234);
        chk("unlock after lockout", int'(bus.m_acw), 1);

        // Lock button held through unlocking has no effect; on first UNLOCKED cycle it locks.
        bus.lock_req = 1'b1;
        count_high(0, n);  chk("acw length with lock_req", n, 4);
        chk("unlocked despite lock_req", int'(bus.unlocked), 1);
        @(negedge CLK);
        chk("locking after lock_req", int'(bus.m_cw), 1);
        chk("unlocked cleared", int'(bus.unlocked), 0);
        bus.lock_req = 1'b0;
        count_high(1, n);  chk("cw length lock_req", n, 4);

        // Two fails then an abort must not count as a third failure.
        enter(16'h1235);
        enter(16'h9999);
        press(4'd1);
        press(4'd2);
        press(4'hA);
        enter(16'h1234);
        chk("unlock after abort", int'(bus.m_acw), 1);
        chk("no alarm after abort", int'(bus.alarm), 0);
        count_high(0, n);
        count_high(2, n);  chk("relock delay 2", n, 20);
        count_high(1, n);

        // Reset during the motor pulse.
        enter(16'h1234);
        @(negedge CLK);
        chk("acw 2nd cycle", int'(bus.m_acw), 1);
        RST_N = 1'b0;
        #1;
        chk("acw killed by reset", int'(bus.m_acw), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk_idle("after reset release");
        enter(16'h1234);
        chk("unlock after reset", int'(bus.m_acw), 1);
        count_high(0, n);  chk("acw length after reset", n, 4);
        bus.lock_req = 1'b1;
        @(negedge CLK);
        bus.lock_req = 1'b0;
        count_high(1, n);  chk("cw after reset test", n, 4);
        repeat (2) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
